// File: rtl/layer_compositor_if.sv
// Pixel-path bundle between the layer generators / VGA register and layer_compositor.
// The master side drives pixels and mask control; the slave side returns the composited pixel.
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 3
);
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                               visible;
    logic                               frame_start;
    logic [NUM_LAYERS*(COLOR_W+1)-1:0]  layer_in;
    logic                               mask_wr;
    logic [NUM_LAYERS-1:0]              mask_data;
    logic [NUM_LAYERS-1:0]              blink_mask;
    logic [COLOR_W-1:0]                 bg_color;

    logic [COLOR_W-1:0]                 oRGB;
    logic                               o_visible;
    logic                               o_hit;
    logic [LW-1:0]                      o_layer;
    logic [NUM_LAYERS-1:0]              o_collide;

    modport master (
        output visible, frame_start, layer_in, mask_wr, mask_data, blink_mask, bg_color,
        input  oRGB, o_visible, o_hit, o_layer, o_collide
    );

    modport slave (
        input  visible, frame_start, layer_in, mask_wr, mask_data, blink_mask, bg_color,
        output oRGB, o_visible, o_hit, o_layer, o_collide
    );
endinterface

// File: rtl/layer_compositor.sv
// Pipelined priority compositor: lowest-indexed eligible layer wins, with frame-committed
// enable masks and frame-rate blinking. Optional collision flags via COMPOSITOR_COLLIDE_EN.
module layer_compositor #(
    parameter int NUM_LAYERS  = 4,
    parameter int COLOR_W     = 3,
    parameter int PIPE_STAGES = 2,
    parameter int BLINK_DIV   = 16
) (
    input  logic               clock,
    input  logic               reset,
    layer_compositor_if.slave  bus
);
    localparam int SW = COLOR_W + 1;
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic [NUM_LAYERS-1:0] shadow_mask;
    logic [NUM_LAYERS-1:0] active_mask;
    logic [NUM_LAYERS-1:0] eff_mask;
    logic [NUM_LAYERS-1:0] eligible;
    logic [7:0]            blink_cnt;
    logic                  blink_phase;
    logic                  blink_wrap;
    logic                  eff_phase;

    logic                  win_hit;
    logic [LW-1:0]         win_idx;
    logic [COLOR_W-1:0]    win_color;
    logic [COLOR_W-1:0]    s1_rgb;
    logic                  s1_hit;
    logic [LW-1:0]         s1_layer;

    logic [COLOR_W-1:0]    rgb_q   [PIPE_STAGES];
    logic                  vis_q   [PIPE_STAGES];
    logic                  hit_q   [PIPE_STAGES];
    logic [LW-1:0]         layer_q [PIPE_STAGES];

    assign blink_wrap = (blink_cnt == 8'(BLINK_DIV - 1));

    // A frame_start pixel already sees the mask and phase being committed on that edge.
    always_comb begin
        eff_mask = active_mask;
        if (bus.frame_start) begin
            eff_mask = bus.mask_wr ? bus.mask_data : shadow_mask;
        end
    end

    assign eff_phase = blink_phase ^ (bus.frame_start & blink_wrap);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_mask <= '1;
            active_mask <= '1;
        end else begin
            if (bus.mask_wr) begin
                shadow_mask <= bus.mask_data;
            end
            if (bus.frame_start) begin
                active_mask <= eff_mask;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (bus.frame_start) begin
            if (blink_wrap) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eligible[i] = bus.layer_in[i*SW + COLOR_W] & eff_mask[i]
                          & ~(eff_phase & bus.blink_mask[i]);
        end
    end

    // Scan from the top so the lowest-indexed eligible layer is the last to assign.
    always_comb begin
        win_hit   = 1'b0;
        win_idx   = '0;
        win_color = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_hit   = 1'b1;
                win_idx   = LW'(i);
                win_color = bus.layer_in[i*SW +: COLOR_W];
            end
        end
    end

    always_comb begin
        s1_rgb   = '0;
        s1_hit   = 1'b0;
        s1_layer = '0;
        if (bus.visible) begin
            s1_hit   = win_hit;
            s1_rgb   = win_hit ? win_color : bus.bg_color;
            s1_layer = win_hit ? win_idx : '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                rgb_q[s]   <= '0;
                vis_q[s]   <= 1'b0;
                hit_q[s]   <= 1'b0;
                layer_q[s] <= '0;
            end
        end else begin
            rgb_q[0]   <= s1_rgb;
            vis_q[0]   <= bus.visible;
            hit_q[0]   <= s1_hit;
            layer_q[0] <= s1_layer;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                rgb_q[s]   <= rgb_q[s-1];
                vis_q[s]   <= vis_q[s-1];
                hit_q[s]   <= hit_q[s-1];
                layer_q[s] <= layer_q[s-1];
            end
        end
    end

    assign bus.oRGB      = rgb_q[PIPE_STAGES-1];
    assign bus.o_visible = vis_q[PIPE_STAGES-1];
    assign bus.o_hit     = hit_q[PIPE_STAGES-1];
    assign bus.o_layer   = layer_q[PIPE_STAGES-1];

`ifdef COMPOSITOR_COLLIDE_EN
    logic [NUM_LAYERS-1:0] collide_now;
    logic [NUM_LAYERS-1:0] collide_acc;
    logic [NUM_LAYERS-1:0] collide_q;

    always_comb begin
        collide_now = '0;
        for (int i = 1; i < NUM_LAYERS; i++) begin
            collide_now[i] = bus.visible & eligible[0] & eligible[i];
        end
    end

    // The frame_start pixel's own overlap is folded into the published flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            collide_acc <= '0;
            collide_q   <= '0;
        end else if (bus.frame_start) begin
            collide_q   <= collide_acc | collide_now;
            collide_acc <= '0;
        end else begin
            collide_acc <= collide_acc | collide_now;
        end
    end

    assign bus.o_collide = collide_q;
`else
    assign bus.o_collide = '0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: one instance each with PIPE_STAGES 1, 2 and 4,
// all with BLINK_DIV=2 and driven from the same stimulus.
module tb_layer_compositor;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        visible = 1'b0;
    logic        frame_start = 1'b0;
    logic        mask_wr = 1'b0;
    logic [15:0] layer_in = '0;
    logic [3:0]  mask_data = '0;
    logic [3:0]  blink_mask = '0;
    logic [2:0]  bg_color = '0;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clock = ~clock;

    layer_compositor_if #(.NUM_LAYERS(4), .COLOR_W(3)) bus1 ();
    layer_compositor_if #(.NUM_LAYERS(4), .COLOR_W(3)) bus2 ();
    layer_compositor_if #(.NUM_LAYERS(4), .COLOR_W(3)) bus4 ();

    assign bus1.visible = visible;     assign bus2.visible = visible;     assign bus4.visible = visible;
    assign bus1.frame_start = frame_start; assign bus2.frame_start = frame_start; assign bus4.frame_start = frame_start;
    assign bus1.layer_in = layer_in;   assign bus2.layer_in = layer_in;   assign bus4.layer_in = layer_in;
    assign bus1.mask_wr = mask_wr;     assign bus2.mask_wr = mask_wr;     assign bus4.mask_wr = mask_wr;
    assign bus1.mask_data = mask_data; assign bus2.mask_data = mask_data; assign bus4.mask_data = mask_data;
    assign bus1.blink_mask = blink_mask; assign bus2.blink_mask = blink_mask; assign bus4.blink_mask = blink_mask;
    assign bus1.bg_color = bg_color;   assign bus2.bg_color = bg_color;   assign bus4.bg_color = bg_color;

    layer_compositor #(.NUM_LAYERS(4), .COLOR_W(3), .PIPE_STAGES(1), .BLINK_DIV(2))
        dut1 (.clock(clock), .reset(reset), .bus(bus1));
    layer_compositor #(.NUM_LAYERS(4), .COLOR_W(3), .PIPE_STAGES(2), .BLINK_DIV(2))
        dut2 (.clock(clock), .reset(reset), .bus(bus2));
    layer_compositor #(.NUM_LAYERS(4), .COLOR_W(3), .PIPE_STAGES(4), .BLINK_DIV(2))
        dut4 (.clock(clock), .reset(reset), .bus(bus4));

    function automatic logic [15:0] lay(input logic [3:0] v, input logic [2:0] c0,
                                        input logic [2:0] c1, input logic [2:0] c2,
                                        input logic [2:0] c3);
        return {v[3], c3, v[2], c2, v[1], c1, v[0], c0};
    endfunction

    function automatic logic [7:0] expo(input logic [2:0] rgb, input logic vis,
                                        input logic hit, input logic [1:0] layer);
        return {1'b0, rgb, vis, hit, layer};
    endfunction

    // Ramp pixel k: only layer k%4 valid with colour k%8; every fifth pixel is blanked.
    function automatic logic [15:0] ramp_pixel(input int k);
        logic [15:0] p;
        p = '0;
        p[(k % 4)*4 +: 4] = {1'b1, 3'(k % 8)};
        return p;
    endfunction

    function automatic logic ramp_vis(input int k);
        return (k % 5) != 4;
    endfunction

    function automatic logic [7:0] ramp_exp(input int k);
        if (!ramp_vis(k)) return expo(3'd0, 1'b0, 1'b0, 2'd0);
        return expo(3'(k % 8), 1'b1, 1'b1, 2'(k % 4));
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic vis, input logic fs, input logic [15:0] layers,
                                 input int cycles);
        visible     = vis;
        frame_start = fs;
        layer_in    = layers;
        tick();
        frame_start = 1'b0;
        mask_wr     = 1'b0;
        for (int n = 1; n < cycles; n++) tick();
    endtask

    task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] expv);
        check_count++;
        assert (got === expv) pass_count++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, got, expv);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expv);
        checkVal(tag, {1'b0, bus2.oRGB, bus2.o_visible, bus2.o_hit, bus2.o_layer}, expv);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] l01;
        l01 = lay(4'b0011, 3'd1, 3'd2, 3'd0, 3'd0);
        $display("[TB] starting layer_compositor bench");
        tick(); tick();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, lay(4'b0001, 3'd6, 3'd0, 3'd0, 3'd0), 3);

        // Reset mid-stream with live inputs: everything flushes to zero.
        reset = 1'b0;
        tick(); tick(); tick();
        checkOutput("reset_flush", expo(3'd0, 1'b0, 1'b0, 2'd0));
        checkVal("reset_collide", {4'd0, bus2.o_collide}, 8'd0);
        checkVal("reset_flush_p4", {1'b0, bus4.oRGB, bus4.o_visible, bus4.o_hit, bus4.o_layer}, 8'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, lay(4'b0010, 3'd0, 3'b101, 3'd0, 3'd0), 1);
        checkOutput("latency_early", expo(3'd0, 1'b0, 1'b0, 2'd0));
        tick();
        checkOutput("latency_first", expo(3'b101, 1'b1, 1'b1, 2'd1));

        // Priority.
        bg_color = 3'b111;
        applyStimulus(1'b1, 1'b0, lay(4'b1111, 3'd1, 3'd2, 3'd3, 3'd4), 2);
        checkOutput("prio_all", expo(3'd1, 1'b1, 1'b1, 2'd0));
        applyStimulus(1'b1, 1'b0, lay(4'b1110, 3'd1, 3'd2, 3'd3, 3'd4), 2);
        checkOutput("prio_drop0", expo(3'd2, 1'b1, 1'b1, 2'd1));
        applyStimulus(1'b1, 1'b0, lay(4'b0000, 3'd1, 3'd2, 3'd3, 3'd4), 2);
        checkOutput("prio_bg", expo(3'b111, 1'b1, 1'b0, 2'd0));
        applyStimulus(1'b0, 1'b0, lay(4'b1111, 3'd1, 3'd2, 3'd3, 3'd4), 2);
        checkOutput("prio_blank", expo(3'd0, 1'b0, 1'b0, 2'd0));

        // Blink with BLINK_DIV=2 on layer 0.
        blink_mask = 4'b0001;
        applyStimulus(1'b1, 1'b1, l01, 2);
        checkOutput("blink_pulse1", expo(3'd1, 1'b1, 1'b1, 2'd0));
        applyStimulus(1'b1, 1'b1, l01, 2);
        checkOutput("blink_off", expo(3'd2, 1'b1, 1'b1, 2'd1));
        applyStimulus(1'b1, 1'b1, l01, 2);
        checkOutput("blink_hold", expo(3'd2, 1'b1, 1'b1, 2'd1));
        applyStimulus(1'b1, 1'b1, l01, 2);
        checkOutput("blink_on", expo(3'd1, 1'b1, 1'b1, 2'd0));
        blink_mask = 4'b0000;

        // Mask commit: mid-frame write waits for frame_start; coincident write bypasses.
        mask_wr   = 1'b1;
        mask_data = 4'b1110;
        applyStimulus(1'b1, 1'b0, l01, 2);
        checkOutput("mask_pending", expo(3'd1, 1'b1, 1'b1, 2'd0));
        applyStimulus(1'b1, 1'b1, l01, 2);
        checkOutput("mask_commit", expo(3'd2, 1'b1, 1'b1, 2'd1));
        mask_wr   = 1'b1;
        mask_data = 4'b1111;
        applyStimulus(1'b1, 1'b1, l01, 2);
        checkOutput("mask_bypass", expo(3'd1, 1'b1, 1'b1, 2'd0));

        // Continuous ramp through all three pipeline depths.
        for (int k = 0; k < 14; k++) begin
            applyStimulus(ramp_vis(k), 1'b0, ramp_pixel(k), 1);
            checkVal($sformatf("ramp_p1_%0d", k),
                     {1'b0, bus1.oRGB, bus1.o_visible, bus1.o_hit, bus1.o_layer}, ramp_exp(k));
            if (k >= 1)
                checkVal($sformatf("ramp_p2_%0d", k - 1),
                         {1'b0, bus2.oRGB, bus2.o_visible, bus2.o_hit, bus2.o_layer}, ramp_exp(k - 1));
            if (k >= 3)
                checkVal($sformatf("ramp_p4_%0d", k - 3),
                         {1'b0, bus4.oRGB, bus4.o_visible, bus4.o_hit, bus4.o_layer}, ramp_exp(k - 3));
        end

        // Collision flags: clear, overlap layers 0 and 2 once, publish; then a clean frame.
        applyStimulus(1'b1, 1'b1, 16'd0, 1);
        applyStimulus(1'b1, 1'b0, lay(4'b0101, 3'd1, 3'd0, 3'd3, 3'd0), 1);
        applyStimulus(1'b1, 1'b0, 16'd0, 2);
        applyStimulus(1'b1, 1'b1, 16'd0, 1);
`ifdef COMPOSITOR_COLLIDE_EN
        checkVal("collide_overlap", {4'd0, bus2.o_collide}, 8'b0000_0100);
`else
        checkVal("collide_overlap", {4'd0, bus2.o_collide}, 8'd0);
`endif
        applyStimulus(1'b1, 1'b0, lay(4'b0001, 3'd1, 3'd0, 3'd0, 3'd0), 2);
        applyStimulus(1'b1, 1'b1, 16'd0, 1);
        checkVal("collide_clean", {4'd0, bus2.o_collide}, 8'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined priority compositor for the VGA path.
- Merges NUM_LAYERS sprite/tile layers (ball, blocks, paddle, background, overlays) into one pixel colour.
- Adds per-layer enable masking committed at frame boundaries, frame-rate blinking of selected layers, and a configurable pipeline depth with matched visible delay.
- Sits between the layer generators and the VGA output register.

Parameters:
- NUM_LAYERS, 4, number of input layers; layer 0 has the highest priority.
- COLOR_W, 3, colour bits per layer and at the output.
- PIPE_STAGES, 2, input-to-output latency in clocks; legal range 1..4.
- BLINK_DIV, 16, frames per blink half-period; legal range 1..255.

Ports:
- clock  in  1  pixel clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- visible  in  1  pixel is inside the active display area.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- layer_in  in  NUM_LAYERS*(COLOR_W+1)  slice i is {valid_i, color_i}, with layer i at bits [(i+1)*(COLOR_W+1)-1 : i*(COLOR_W+1)].
- mask_wr  in  1  write strobe for the layer enable mask.
- mask_data  in  NUM_LAYERS  new enable mask; 1 = layer enabled.
- blink_mask  in  NUM_LAYERS  layers suppressed during the blink-off phase.
- bg_color  in  COLOR_W  colour used when no layer hits.
- oRGB  out  COLOR_W  composited pixel colour.
- o_visible  out  1  visible, delayed by PIPE_STAGES.
- o_hit  out  1  some layer won the pixel.
- o_layer  out  clog2(NUM_LAYERS) (minimum 1)  index of the winning layer.
- o_collide  out  NUM_LAYERS  per-layer collision flags for the previous frame (optional feature).

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - oRGB, o_visible, o_hit, o_layer, o_collide and all pipeline registers to 0.
  - Shadow mask and active mask to all ones.
  - Blink counter to 0 and blink phase to 0 (on).
- Release is synchronous to clock.
- Reset asserted mid-frame flushes the pipeline; the first valid output appears PIPE_STAGES cycles after the first post-reset input.
- Mask write:
  - mask_wr=1 loads mask_data into the shadow mask.
  - The active mask loads from the shadow only on frame_start.
  - If mask_wr and frame_start coincide, the active mask takes mask_data directly (bypass).
- Blink:
  - On each frame_start: if counter==BLINK_DIV-1, counter←0 and phase toggles; otherwise counter increments.
  - While phase=1, layers with blink_mask[i]=1 are treated as not valid.
- Layer i is eligible when valid_i & active_mask[i] & ~(phase & blink_mask[i]).
- The winner is the lowest-indexed eligible layer.
- Stage 1 registers the winner colour, the winner index, the hit flag and visible.
- Stages 2..PIPE_STAGES are plain delay registers.
- Output rules:
  - o_visible=0 forces oRGB=0, o_hit=0 and o_layer=0.
  - Otherwise, if no layer is eligible: oRGB=bg_color (sampled in stage 1), o_hit=0, o_layer=0.
- Latency is exactly PIPE_STAGES clocks for every output, with no bubbles; the block accepts one pixel per clock continuously.
- frame_start affects masking and blinking from the pixel sampled in the same cycle onward.

Optional Feature:
- Macro: COMPOSITOR_COLLIDE_EN.
- When defined:
  - A sticky accumulator bit i sets when layer 0 and layer i (i≥1) are both eligible on the same visible pixel.
  - On frame_start, o_collide takes the accumulator value, including a collision on that same cycle, and the accumulator clears.
  - o_collide[0] is always 0.
- When not defined: o_collide is tied to 0 and no accumulator logic exists.

Test Plan:
- Reset mid-stream (PIPE_STAGES=2): hold reset=0 for 3 cycles → all outputs 0. After release, apply layer1={1,3'b101}, visible=1 → oRGB=3'b101, o_layer=1, o_hit=1 exactly 2 cycles later.
- Priority: layers 0..3 all valid with colours 1,2,3,4 → oRGB=1. Drop layer 0 → oRGB=2. None valid with bg_color=3'b111 → oRGB=7, o_hit=0. Drive visible=0 → oRGB=0.
- Mask commit: mask_wr with mask_data=4'b1110 mid-frame → layer 0 still wins until the next frame_start, after which layer 1 wins. Repeat with mask_wr coincident with frame_start → change takes effect on that pixel.
- Blink (BLINK_DIV=2, blink_mask=4'b0001): 2 frame_start pulses → layer 0 suppressed, layer 1 wins. 2 more pulses → layer 0 wins again.
- Latency sweep: PIPE_STAGES=1 and 4 with a continuous pixel ramp → output equals the input sequence delayed by 1 and 4 cycles respectively, and o_visible is aligned with it.
- COMPOSITOR_COLLIDE_EN: layer 0 and layer 2 overlap on one visible pixel, then frame_start → o_collide=4'b0100. Next frame with no overlap, then frame_start → o_collide=0.
